// File: rtl/alu_pkg.sv
// Shared opcode constants and FSM state encoding for alu_arbiter, its ALU and benches.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package alu_pkg;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_INC  = 4'b0001;
  localparam logic [3:0] OP_SUB  = 4'b0010;
  localparam logic [3:0] OP_DEC  = 4'b0011;
  localparam logic [3:0] OP_MUL  = 4'b0100;
  localparam logic [3:0] OP_DIV  = 4'b0101;
  localparam logic [3:0] OP_SHL  = 4'b0110;
  localparam logic [3:0] OP_SHR  = 4'b0111;
  localparam logic [3:0] OP_AND  = 4'b1000;
  localparam logic [3:0] OP_OR   = 4'b1001;
  localparam logic [3:0] OP_INV  = 4'b1010;
  localparam logic [3:0] OP_NAND = 4'b1011;
  localparam logic [3:0] OP_NOR  = 4'b1100;
  localparam logic [3:0] OP_XOR  = 4'b1101;
  localparam logic [3:0] OP_XNOR = 4'b1110;
  localparam logic [3:0] OP_BUF  = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/alu.sv
// Combinational 16-opcode ALU; result zero-extended to 2*DW, forced to 0 when oe is low.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller qualifies the output with oe.
// Ports: a_in/b_in operands, command_in opcode, oe output enable, d_out result.
module alu
  import alu_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic [DW-1:0]   a_in,
  input  logic [DW-1:0]   b_in,
  input  logic [3:0]      command_in,
  input  logic            oe,
  output logic [2*DW-1:0] d_out
);

  logic [2*DW-1:0] w_a;
  logic [2*DW-1:0] w_b;
  logic [2*DW-1:0] w_res;

  assign w_a = {{DW{1'b0}}, a_in};
  assign w_b = {{DW{1'b0}}, b_in};

  // Logic ops work on the DW-bit operands so the upper half stays zero.
  always_comb begin
    w_res = '0;
    case (command_in)
      OP_ADD:  w_res = w_a + w_b;
      OP_INC:  w_res = w_a + 1'b1;
      OP_SUB:  w_res = w_a - w_b;
      OP_DEC:  w_res = w_a - 1'b1;
      OP_MUL:  w_res = w_a * w_b;
      OP_DIV:  w_res = (b_in == '0) ? '1 : (w_a / w_b);
      OP_SHL:  w_res = w_a << 1;
      OP_SHR:  w_res = w_a >> 1;
      OP_AND:  w_res = {{DW{1'b0}}, a_in & b_in};
      OP_OR:   w_res = {{DW{1'b0}}, a_in | b_in};
      OP_INV:  w_res = {{DW{1'b0}}, ~a_in};
      OP_NAND: w_res = {{DW{1'b0}}, ~(a_in & b_in)};
      OP_NOR:  w_res = {{DW{1'b0}}, ~(a_in | b_in)};
      OP_XOR:  w_res = {{DW{1'b0}}, a_in ^ b_in};
      OP_XNOR: w_res = {{DW{1'b0}}, ~(a_in ^ b_in)};
      OP_BUF:  w_res = w_a;
      default: w_res = '0;
    endcase
  end

  assign d_out = oe ? w_res : '0;

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between two requesters (IDLE -> EXEC -> DONE).
// Latency: req sampled at edge k, gnt in cycle k..k+1, done/result in k+1..k+2, next grant at k+3.
// Backpressure: req is ignored while busy; a requester holds req until its gnt pulse.
// Ports: clk/rst; req0/req1 with a*/b*/cmd* operands; gnt*/done* pulses; result, err, busy.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req0,
  input  logic            req1,
  input  logic [DW-1:0]   a0,
  input  logic [DW-1:0]   b0,
  input  logic [DW-1:0]   a1,
  input  logic [DW-1:0]   b1,
  input  logic [3:0]      cmd0,
  input  logic [3:0]      cmd1,
  output logic            gnt0,
  output logic            gnt1,
  output logic            done0,
  output logic            done1,
  output logic [2*DW-1:0] result,
  output logic            err,
  output logic            busy
);

  state_t          r_state;
  state_t          w_state_nxt;
  logic            r_last;      // requester granted most recently; owns EXEC/DONE
  logic [DW-1:0]   r_a;
  logic [DW-1:0]   r_b;
  logic [3:0]      r_cmd;
  logic [2*DW-1:0] r_result;
  logic            r_err;

  logic            w_take;
  logic            w_sel;
  logic            w_oe;
  logic            w_div0;
  logic [2*DW-1:0] w_alu_out;

  // Requester 1 wins when alone, or under contention when 0 was granted last.
  assign w_sel  = req1 & (~req0 | ~r_last);
  assign w_div0 = (r_cmd == OP_DIV) && (r_b == '0);

  alu #(.DW(DW)) u_alu (
    .a_in       (r_a),
    .b_in       (r_b),
    .command_in (r_cmd),
    .oe         (w_oe),
    .d_out      (w_alu_out)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_last   <= 1'b1;      // so requester 0 wins the first contention
      r_a      <= '0;
      r_b      <= '0;
      r_cmd    <= '0;
      r_result <= '0;
      r_err    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_take) begin
        r_last <= w_sel;
        r_a    <= w_sel ? a1 : a0;
        r_b    <= w_sel ? b1 : b0;
        r_cmd  <= w_sel ? cmd1 : cmd0;
      end
      if (r_state == ST_EXEC) begin
        r_result <= w_div0 ? '1 : w_alu_out;
        r_err    <= w_div0;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_take      = 1'b0;
    w_oe        = 1'b0;
    gnt0        = 1'b0;
    gnt1        = 1'b0;
    done0       = 1'b0;
    done1       = 1'b0;
    err         = 1'b0;
    busy        = 1'b1;
    case (r_state)
      ST_IDLE: begin
        busy = 1'b0;
        if (req0 || req1) begin
          w_state_nxt = ST_EXEC;
          w_take      = 1'b1;
        end
      end
      ST_EXEC: begin
        w_state_nxt = ST_DONE;
        w_oe        = 1'b1;
        gnt0        = ~r_last;
        gnt1        = r_last;
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
        done0       = ~r_last;
        done1       = r_last;
        err         = r_err;
      end
      default: begin
        w_state_nxt = ST_IDLE;
        busy        = 1'b0;
      end
    endcase
  end

  assign result = r_result;

endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;
  import alu_pkg::*;

  localparam int DW = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic            req0, req1;
  logic [DW-1:0]   a0, b0, a1, b1;
  logic [3:0]      cmd0, cmd1;
  logic            gnt0, gnt1, done0, done1, err, busy;
  logic [2*DW-1:0] result;

  typedef struct packed {
    logic        who;
    logic [15:0] res;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  alu_arbiter #(.DW(DW)) dut (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1), .cmd0(cmd0), .cmd1(cmd1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .result(result), .err(err), .busy(busy)
  );

  always #5 clk = ~clk;

  // Scoreboard: every done pulse pops and checks one expected completion.
  always @(negedge clk) begin
    if (gnt0 && gnt1) begin
      fails++;
      $display("FAIL excl_gnt: both grants high at %0t", $time);
    end
    if (done0 && done1) begin
      fails++;
      $display("FAIL excl_done: both dones high at %0t", $time);
    end
    if (done0 || done1) begin
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL sb_unexpected: done0=%0b done1=%0b with nothing expected", done0, done1);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (done1 !== e.who || result !== e.res || err !== e.err) begin
          fails++;
          $display("FAIL sb_done: got who=%0b result=%h err=%0b, want who=%0b result=%h err=%0b",
                   done1, result, err, e.who, e.res, e.err);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (!busy && sb.size() == 0) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (!ok) begin
      tests++;
      fails++;
      $display("FAIL wait_idle: busy=%0b pending=%0d after 20 cycles", busy, sb.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req0 = 1'b1;
    tick();
    tick();
    tests++;
    if ({busy, gnt0, gnt1, done0, done1, err} !== 6'b0) begin
      fails++;
      $display("FAIL reset_ctrl: busy/gnt0/gnt1/done0/done1/err=%b want 000000",
               {busy, gnt0, gnt1, done0, done1, err});
    end
    tests++;
    if (result !== 16'h0) begin
      fails++;
      $display("FAIL reset_result: got %h want 0000", result);
    end
    req0 = 1'b0;
    rst  = 1'b0;
    tick();
  endtask

  task automatic test_single();
    req0 = 1'b1; a0 = 8'd20; b0 = 8'd10; cmd0 = OP_ADD;
    sb.push_back('{who: 1'b0, res: 16'd30, err: 1'b0});
    tick();
    tests++;
    if ({gnt0, gnt1, busy} !== 3'b101) begin
      fails++;
      $display("FAIL single_gnt: gnt0/gnt1/busy=%b want 101", {gnt0, gnt1, busy});
    end
    req0 = 1'b0;
    tick();
    tests++;
    if ({done0, gnt0} !== 2'b10) begin
      fails++;
      $display("FAIL single_done: done0/gnt0=%b want 10", {done0, gnt0});
    end
    tick();
    tests++;
    if (busy !== 1'b0 || result !== 16'd30) begin
      fails++;
      $display("FAIL single_hold: busy=%0b result=%h want busy=0 result=001e", busy, result);
    end
    wait_idle();
  endtask

  task automatic test_contention();
    logic [1:0] want;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req0 = 1'b1; a0 = 8'd5; b0 = 8'd2; cmd0 = OP_ADD;
    req1 = 1'b1; a1 = 8'd9; b1 = 8'd4; cmd1 = OP_SUB;
    sb.push_back('{who: 1'b0, res: 16'd7, err: 1'b0});
    sb.push_back('{who: 1'b1, res: 16'd5, err: 1'b0});
    sb.push_back('{who: 1'b0, res: 16'd7, err: 1'b0});
    for (int cyc = 1; cyc <= 9; cyc++) begin
      tick();
      want = (cyc == 1 || cyc == 7) ? 2'b01 : (cyc == 4) ? 2'b10 : 2'b00;
      tests++;
      if ({gnt1, gnt0} !== want) begin
        fails++;
        $display("FAIL contention_cyc%0d: gnt1/gnt0=%b want %b", cyc, {gnt1, gnt0}, want);
      end
      if (cyc == 7) begin
        req0 = 1'b0;
        req1 = 1'b0;
      end
    end
    wait_idle();
  endtask

  task automatic test_div_zero();
    req1 = 1'b1; a1 = 8'd25; b1 = 8'd0; cmd1 = OP_DIV;
    sb.push_back('{who: 1'b1, res: 16'hFFFF, err: 1'b1});
    tick();
    tests++;
    if ({gnt1, gnt0} !== 2'b10) begin
      fails++;
      $display("FAIL div0_gnt: gnt1/gnt0=%b want 10", {gnt1, gnt0});
    end
    req1 = 1'b0;
    tick();
    tests++;
    if ({done1, err} !== 2'b11) begin
      fails++;
      $display("FAIL div0_done: done1/err=%b want 11", {done1, err});
    end
    wait_idle();
  endtask

  task automatic test_reset_mid();
    req0 = 1'b1; a0 = 8'd1; b0 = 8'd1; cmd0 = OP_ADD;
    tick();
    tests++;
    if (gnt0 !== 1'b1) begin
      fails++;
      $display("FAIL rstmid_gnt: gnt0=%0b want 1", gnt0);
    end
    req0 = 1'b0;
    rst  = 1'b1;
    tick();
    rst = 1'b0;
    tests++;
    if ({done0, done1, busy} !== 3'b000 || result !== 16'h0) begin
      fails++;
      $display("FAIL rstmid_abort: done0/done1/busy=%b result=%h want 000 0000",
               {done0, done1, busy}, result);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      tests++;
      if ({done0, done1} !== 2'b00) begin
        fails++;
        $display("FAIL rstmid_nodone%0d: done0/done1=%b want 00", i, {done0, done1});
      end
    end
  endtask

  task automatic test_drop_early();
    int seen = 0;
    req0 = 1'b1; a0 = 8'd3; b0 = 8'd4; cmd0 = OP_ADD;
    sb.push_back('{who: 1'b0, res: 16'd7, err: 1'b0});
    tick();
    tests++;
    if (gnt0 !== 1'b1) begin
      fails++;
      $display("FAIL drop_gnt0: gnt0=%0b want 1", gnt0);
    end
    req0 = 1'b0;
    req1 = 1'b1; a1 = 8'd8; b1 = 8'd8; cmd1 = OP_MUL;
    tick();
    req1 = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (gnt1 || done1) seen++;
      tick();
    end
    tests++;
    if (seen != 0) begin
      fails++;
      $display("FAIL drop_req1: gnt1/done1 seen %0d cycles, want 0", seen);
    end
    wait_idle();
  endtask

  task automatic test_opcode_sweep();
    logic [15:0] tab [16];
    tab[0]  = 16'd18;   tab[1]  = 16'd16;   tab[2]  = 16'd12;   tab[3]  = 16'd14;
    tab[4]  = 16'd45;   tab[5]  = 16'd5;    tab[6]  = 16'd30;   tab[7]  = 16'd7;
    tab[8]  = 16'h0003; tab[9]  = 16'h000F; tab[10] = 16'h00F0; tab[11] = 16'h00FC;
    tab[12] = 16'h00F0; tab[13] = 16'h000C; tab[14] = 16'h00F3; tab[15] = 16'h000F;
    for (int op = 0; op < 16; op++) begin
      bit got = 1'b0;
      req0 = 1'b1; a0 = 8'd15; b0 = 8'd3; cmd0 = op[3:0];
      sb.push_back('{who: 1'b0, res: tab[op], err: 1'b0});
      for (int i = 0; i < 10; i++) begin
        tick();
        if (gnt0) begin
          got = 1'b1;
          break;
        end
      end
      req0 = 1'b0;
      if (!got) begin
        tests++;
        fails++;
        $display("FAIL sweep_gnt_op%0d: no gnt0 within 10 cycles", op);
      end
      wait_idle();
    end
  endtask

  initial begin
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0; cmd0 = '0; cmd1 = '0;
    tick();
    test_reset();
    test_single();
    test_contention();
    test_div_zero();
    test_reset_mid();
    test_drop_early();
    test_opcode_sweep();
    repeat (3) tick();
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL sb_drain: %0d expected completions never seen, want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter: DW, 8, operand width; result width is 2*DW.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port: rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have ports: req0 / req1  input  1 each  requester 0 / 1 operation request.
REQ-005 SHALL have ports: a0 / b0 / a1 / b1  input  DW each  requester operands.
REQ-006 SHALL have ports: cmd0 / cmd1  input  4 each  requester ALU opcodes.
REQ-007 SHALL have ports: gnt0 / gnt1  output  1 each  one-cycle grant pulse; operands accepted.
REQ-008 SHALL have ports: done0 / done1  output  1 each  one-cycle completion pulse for the granted requester.
REQ-009 SHALL have port: result  output  2*DW  result of the last completed operation.
REQ-010 SHALL have port: err  output  1  high with done when the completed operation was DIV with b = 0.
REQ-011 SHALL have port: busy  output  1  high whenever state is not IDLE.

Function
REQ-012 SHALL implement FSM states IDLE, EXEC and DONE.
- IDLE -> EXEC when any req is sampled high.
- EXEC -> DONE unconditionally.
- DONE -> IDLE unconditionally.
REQ-013 SHALL, on the IDLE->EXEC edge, latch the selected requester's a, b and cmd, and SHALL assert that requester's gnt for exactly the EXEC cycle.
REQ-014 SHALL drive the shared alu from the latched operands, with oe = 1 in EXEC and oe = 0 in all other states.
REQ-015 SHALL, on the EXEC->DONE edge, register the alu output into result, and SHALL assert the matching done for exactly the DONE cycle.
REQ-016 Latency SHALL be fixed:
- req sampled at edge k;
- gnt high in cycle k..k+1;
- done and result valid in cycle k+1..k+2;
- next grant no earlier than edge k+3.
REQ-017 SHALL hold result stable from one DONE until the next EXEC->DONE edge.
REQ-018 SHALL arbitrate round-robin:
- single requester: granted;
- both requesting: the one not granted last wins;
- the last-granted pointer updates on each grant.
REQ-019 SHALL ignore req during EXEC and DONE; a requester SHALL hold req until gnt, and a req dropped before grant is not serviced.
REQ-020 SHALL treat req still high in IDLE after done as a new transaction.
REQ-021 SHALL, for opcode DIV (4'b0101) with latched b = 0, force result = all ones and err = 1 instead of the alu output.
REQ-022 SHALL accept all 16 opcodes (ADD 0000 … BUF 1111) without decoding, except the DIV check in REQ-021.
REQ-023 SHALL never assert gnt0 and gnt1, or done0 and done1, in the same cycle.

Reset
REQ-024 SHALL, while rst is high at a clock edge:
- enter IDLE;
- clear result, err, gnt0/1, done0/1, busy and latched operands to 0;
- set the round-robin pointer so requester 0 wins the first contention.
REQ-025 SHALL, on rst mid-transaction (EXEC or DONE), abort without asserting done; rst has priority over all other events.

Structure
REQ-026 SHALL place the opcode constants (ADD … BUF) and the FSM state encoding in shared package alu_pkg, used by alu_arbiter and the benches.
REQ-027 SHALL instantiate the existing alu module as its single sub-module, port order a_in, b_in, command_in, oe, d_out.

Verification
REQ-028 SHALL cover single request: req0, a0=20, b0=10, cmd0=ADD -> gnt0 one cycle later, done0 next cycle, result=30, err=0.
REQ-029 SHALL cover contention after reset: req0 and req1 both high continuously -> grants alternate gnt0, gnt1, gnt0, with one grant every 3 cycles.
REQ-030 SHALL cover divide by zero: req1, a1=25, b1=0, cmd1=DIV -> done1, result=16'hFFFF, err=1.
REQ-031 SHALL cover reset mid-operation: rst asserted in EXEC -> no done pulse, busy=0 and result=0 after the edge.
REQ-032 SHALL cover request dropped early: req1 pulsed for one cycle during another requester's EXEC -> never granted, no done1.
REQ-033 SHALL cover an opcode sweep: requester 0 issues all 16 opcodes with a=15, b=3 -> each result matches the alu reference model (e.g. MUL=45, SUB=12, SHL=30).
